mul_div_seq: RTL and testbench

MUL_DIV_SEQ -- requirements
Module: mul_div_seq

---
 rtl/mul_div_seq.sv | 172 +++++++++++++++++
 tb/tb_mul_div_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq.sv
// Sequential RISC-V M-extension unit: one-bit-per-cycle shift-add multiply and
// restoring divide on operand magnitudes, followed by a single sign-fix cycle.
module mul_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [5:0]      LAST_CNT = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] oper_q, oper_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;

  logic            sgn_a_op_s, sgn_b_op_s, neg_a_s, neg_b_s;
  logic            div_zero_s, overflow_s, ge_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s, quot_fix_s, rem_fix_s, fix_result_s;
  logic [XLEN:0]   sum_s, shifted_s, diff_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;

  // Decode signedness and shortcut cases from the incoming request
  always_comb begin
    // MUL is treated as signed*signed; its low half is sign-agnostic anyway
    sgn_a_op_s = !((funct3 == 3'd3) || (funct3[2] && funct3[0]));
    sgn_b_op_s = (!funct3[2] && !funct3[1]) || (funct3[2] && !funct3[0]);
    neg_a_s    = sgn_a_op_s && op_a[XLEN-1];
    neg_b_s    = sgn_b_op_s && op_b[XLEN-1];
    mag_a_s    = neg_a_s ? -op_a : op_a;
    mag_b_s    = neg_b_s ? -op_b : op_b;
    div_zero_s = funct3[2] && (op_b == '0);
    overflow_s = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
  end

  // Per-cycle datapath step and final sign correction
  always_comb begin
    sum_s      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, oper_q} : {(XLEN+1){1'b0}});
    shifted_s  = {hi_q, lo_q[XLEN-1]};
    diff_s     = shifted_s - {1'b0, oper_q};
    ge_s       = !diff_s[XLEN];
    prod_s     = {hi_q, lo_q};
    prod_fix_s = (sign_a_q ^ sign_b_q) ? -prod_s : prod_s;
    quot_fix_s = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_fix_s  = sign_a_q ? -hi_q : hi_q;
    case (funct3_q)
      3'd0:             fix_result_s = prod_fix_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_result_s = prod_fix_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_result_s = quot_fix_s;
      default:          fix_result_s = rem_fix_s;
    endcase
  end

  // Next-state and datapath register update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    oper_d   = oper_q;
    result_d = result_q;
    funct3_d = funct3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          funct3_d = funct3;
          sign_a_d = neg_a_s;
          sign_b_d = neg_b_s;
          cnt_d    = 6'd0;
          hi_d     = '0;
          if (div_zero_s) begin
            result_d = funct3[1] ? op_a : '1;
            state_d  = DONE;
          end else if (overflow_s) begin
            result_d = funct3[1] ? '0 : op_a;
            state_d  = DONE;
          end else begin
            // lo holds the multiplier (shifted out) or the dividend (shifted into hi)
            lo_d    = funct3[2] ? mag_a_s : mag_b_s;
            oper_d  = funct3[2] ? mag_b_s : mag_a_s;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (funct3_q[2]) begin
            hi_d = ge_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ge_s};
          end else begin
            hi_d = sum_s[XLEN:1];
            lo_d = {sum_s[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == LAST_CNT) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          result_d = fix_result_s;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      hi_q     <= '0;
      lo_q     <= '0;
      oper_q   <= '0;
      result_q <= '0;
      funct3_q <= 3'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      oper_q   <= oper_d;
      result_q <= result_d;
      funct3_q <= funct3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Randomized self-checking bench for mul_div_seq against an arithmetic reference.
module tb_mul_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_result = 32'd0;

  mul_div_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 32'd0) ? a : 32'(sa % sb);
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a falling edge; returns at a falling edge one cycle after done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int          lat;
    int          done_cyc;
    int          busy_bad;
    logic [31:0] exp;
    exp      = ref_result(f, a, b);
    lat      = exp_latency(f, a, b);
    done_cyc = 0;
    busy_bad = 0;
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = 32'($urandom);
    op_b   = 32'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!busy) busy_bad++;
      start = (cyc == 3 && lat > 3);
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    check_eq({tag, " latency"}, done_cyc, lat);
    check_eq({tag, " busy"}, busy_bad, 0);
    check_eq({tag, " result"}, result, exp);
    @(negedge clk);
    check_eq({tag, " idle"}, {30'd0, busy, done}, 32'd0);
    check_eq({tag, " hold"}, result, exp);
    last_result = exp;
  endtask

  initial begin
    int saw;
    repeat (3) @(negedge clk);
    check_eq("reset_out", {30'd0, busy, done}, 32'd0);
    check_eq("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_neg");
    check_eq("mul_neg_const", last_result, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    run_op(3'd4, 32'd100, 32'd0, "div_zero");
    run_op(3'd7, 32'd100, 32'd0, "remu_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");

    // Flush at cycle 10 with an ignored start at cycle 5
    start = 1'b1; funct3 = 3'd0; op_a = 32'd12345; op_b = 32'd678;
    @(posedge clk);
    #1 start = 1'b0;
    saw = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done) saw++;
      start = (cyc == 5);
      if (cyc == 5) begin funct3 = 3'd5; op_b = 32'd0; end
      flush = (cyc == 10);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy", {31'd0, busy}, 32'd0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done || busy) saw++;
    end
    check_eq("flush_no_done", saw, 0);
    check_eq("flush_result", result, last_result);

    // Flush and start together in IDLE
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd0;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    saw = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (done || busy) saw++;
    end
    check_eq("flush_start_drop", saw, 0);
    check_eq("flush_start_result", result, last_result);

    // Asynchronous reset in the middle of CALC
    start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_out", {30'd0, busy, done}, 32'd0);
    check_eq("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done || busy) saw++;
    end
    check_eq("rst_no_done", saw, 0);
    run_op(3'd5, 32'd1000, 32'd7, "after_rst");

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
